// File: rtl/i2c_fifo_pkg.sv
// Shared defaults and types for the I2C word FIFO (TX and RX instances).
package i2c_fifo_pkg;

    localparam int FIFO_DWIDTH = 32;
    localparam int FIFO_AWIDTH = 4;

    // Read/write pointer: one extra MSB distinguishes full from empty.
    typedef logic [FIFO_AWIDTH:0] fifo_ptr_t;

endpackage : i2c_fifo_pkg

// File: rtl/i2c_fifo_mem.sv
// DEPTH x DWIDTH register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module i2c_fifo_mem
    import i2c_fifo_pkg::*;
#(
    parameter int DWIDTH = FIFO_DWIDTH,
    parameter int AWIDTH = FIFO_AWIDTH
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem_q [DEPTH];

    // Store the pushed word at the write index.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : i2c_fifo_mem

// File: rtl/i2c_fifo.sv
// First-word-fall-through FIFO between the APB bridge and the I2C core.
// Optional watermark flags are built when I2C_FIFO_WATERMARK_EN is defined.
module i2c_fifo
    import i2c_fifo_pkg::*;
#(
    parameter int DWIDTH = FIFO_DWIDTH,
    parameter int AWIDTH = FIFO_AWIDTH
) (
    input  logic              PCLK,
    input  logic              PRESET,
`ifdef I2C_FIFO_WATERMARK_EN
    input  logic [AWIDTH:0]   AF_LEVEL,
    input  logic [AWIDTH:0]   AE_LEVEL,
    output logic              ALMOST_FULL,
    output logic              ALMOST_EMPTY,
`endif
    input  logic              WR_EN,
    input  logic [DWIDTH-1:0] WR_DATA,
    input  logic              RD_EN,
    output logic [DWIDTH-1:0] RD_DATA,
    output logic              FULL,
    output logic              EMPTY,
    output logic [AWIDTH:0]   COUNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);

    localparam logic [AWIDTH:0] PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};

    logic [AWIDTH:0]   wptr_q, wptr_d;
    logic [AWIDTH:0]   rptr_q, rptr_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              push_ok;
    logic              pop_ok;
    logic [DWIDTH-1:0] mem_rdata;

    // Status flags come straight from the registered pointers.
    assign EMPTY = (wptr_q == rptr_q);
    assign FULL  = (wptr_q[AWIDTH] != rptr_q[AWIDTH]) &&
                   (wptr_q[AWIDTH-1:0] == rptr_q[AWIDTH-1:0]);
    assign COUNT = wptr_q - rptr_q;

    // A pop is taken whenever data exists; a push is also taken when full
    // if the same-cycle pop frees the head slot.
    assign pop_ok  = RD_EN && !EMPTY && !PRESET;
    assign push_ok = WR_EN && (!FULL || pop_ok) && !PRESET;

    // Next pointer values and error pulses.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = WR_EN && FULL && !(RD_EN && !EMPTY);
        underflow_d = RD_EN && EMPTY;
        if (push_ok) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

    // Pointer and error-pulse registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign OVERFLOW  = overflow_q;
    assign UNDERFLOW = underflow_q;

    i2c_fifo_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk   (PCLK),
        .we    (push_ok),
        .waddr (wptr_q[AWIDTH-1:0]),
        .wdata (WR_DATA),
        .raddr (rptr_q[AWIDTH-1:0]),
        .rdata (mem_rdata)
    );

    // Storage is never cleared, so mask the head word while nothing is held.
    assign RD_DATA = EMPTY ? '0 : mem_rdata;

`ifdef I2C_FIFO_WATERMARK_EN
    logic almost_full_q, almost_full_d;
    logic almost_empty_q, almost_empty_d;

    // Thresholds are compared against the registered fill level.
    always_comb begin
        almost_full_d  = (COUNT >= AF_LEVEL);
        almost_empty_d = (COUNT <= AE_LEVEL);
    end

    // Watermark flags lag COUNT by one cycle.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign ALMOST_FULL  = almost_full_q;
    assign ALMOST_EMPTY = almost_empty_q;
`endif

endmodule : i2c_fifo
